// File: rtl/mpy_32_16_vec.sv
// mpy_32_16_vec: sequential vector form of the G.729 mpy_32_16 multiply.
// Each of LEN 32-bit elements read from scratch memory is multiplied by a
// 16-bit scalar and written back to a destination vector. Every element takes
// 4 cycles (RD, WAIT, CALC, WR). done pulses once after the last write.
// Optional build macro MPY_32_16_VEC_ACC_EN adds acc_out_o, a saturating
// running sum of all results in the current run.
module mpy_32_16_vec #(
  parameter int unsigned LEN    = 10,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic [15:0]       var2_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_rd_data_i,
  output logic [31:0]       mem_wr_data_o,
  output logic              mem_wr_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o
`ifdef MPY_32_16_VEC_ACC_EN
  ,
  output logic [31:0]       acc_out_o
`endif
);

  typedef enum logic [2:0] {StIdle, StRd, StWait, StCalc, StWr, StDone} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       var2_q;
  logic [31:0]       var1_q;
  logic [ADDR_W-1:0] src_q, dst_q, mem_addr_q;
  logic [31:0]       mem_wr_data_q;
  logic              mem_wr_en_q, busy_q, done_q, ovf_q;

  logic signed [15:0] hi, lo, v2;
  logic signed [31:0] lm_prod, mu_prod, lm_res, mu_term;
  logic               lm_sat, mu_sat, calc_ovf;
  logic [32:0]        mac;
  logic [31:0]        calc_res;

  // 32-bit signed add with saturation; bit 32 of the return flags saturation.
  function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31]) return {1'b1, (s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
    return {1'b0, s[31:0]};
  endfunction

  // L_mult(hi, var2) + 2 * mult(lo, var2), each step saturating.
  always_comb begin
    hi      = var1_q[31:16];
    lo      = var1_q[15:0];
    v2      = var2_q;
    lm_prod = 32'(hi) * 32'(v2);
    mu_prod = 32'(lo) * 32'(v2);
    lm_sat  = (hi == 16'sh8000) && (v2 == 16'sh8000);
    mu_sat  = (lo == 16'sh8000) && (v2 == 16'sh8000);
    lm_res  = lm_sat ? 32'sh7FFF_FFFF : (lm_prod <<< 1);
    // mult result is already sign-extended in 32 bits outside the saturating case.
    mu_term = mu_sat ? 32'sh0000_FFFE : ((mu_prod >>> 15) <<< 1);
    mac      = sat_add(lm_res, mu_term);
    calc_res = mac[31:0];
    calc_ovf = lm_sat | mu_sat | mac[32];
  end

`ifdef MPY_32_16_VEC_ACC_EN
  logic [31:0] acc_q;
  logic [32:0] acc_sum;

  // Running sum of the result being written this cycle.
  always_comb begin
    acc_sum = sat_add(acc_q, mem_wr_data_q);
  end

  assign acc_out_o = acc_q;
`endif

  // Element sequencer; all outputs registered, reset wins over everything.
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      var2_q        <= '0;
      var1_q        <= '0;
      src_q         <= '0;
      dst_q         <= '0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_wr_en_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ovf_q         <= 1'b0;
`ifdef MPY_32_16_VEC_ACC_EN
      acc_q         <= '0;
`endif
    end else begin
      done_q      <= 1'b0;
      mem_wr_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            var2_q     <= var2_i;
            src_q      <= src_addr_i;
            dst_q      <= dst_addr_i;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b1;
            mem_addr_q <= src_addr_i;
`ifdef MPY_32_16_VEC_ACC_EN
            acc_q      <= '0;
`endif
            state_q    <= StRd;
          end
        end
        StRd: state_q <= StWait;
        StWait: begin
          var1_q  <= mem_rd_data_i;
          state_q <= StCalc;
        end
        StCalc: begin
          mem_wr_data_q <= calc_res;
          if (calc_ovf) ovf_q <= 1'b1;
          mem_addr_q    <= dst_q + ADDR_W'(cnt_q);
          mem_wr_en_q   <= 1'b1;
          state_q       <= StWr;
        end
        StWr: begin
`ifdef MPY_32_16_VEC_ACC_EN
          acc_q <= acc_sum[31:0];
          if (acc_sum[32]) ovf_q <= 1'b1;
`endif
          if (cnt_q == CNT_W'(LEN - 1)) begin
            state_q <= StDone;
          end else begin
            cnt_q      <= cnt_q + CNT_W'(1);
            mem_addr_q <= src_q + ADDR_W'(cnt_q + CNT_W'(1));
            state_q    <= StRd;
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_addr_o    = mem_addr_q;
  assign mem_wr_data_o = mem_wr_data_q;
  assign mem_wr_en_o   = mem_wr_en_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_mpy_32_16_vec.sv
// Bench for mpy_32_16_vec: LEN=1 and LEN=10 instances (plus LEN=2 when
// MPY_32_16_VEC_ACC_EN is defined), each with its own scratch memory model.
module tb_mpy_32_16_vec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic [15:0] var2 = '0;
  logic [11:0] src = '0, dst = '0;
  logic        start1 = 1'b0, start10 = 1'b0;
  logic        ld_en = 1'b0;
  int          ld_sel = 0;
  logic [11:0] ld_addr = '0;
  logic [31:0] ld_data = '0;

  logic [11:0] addr1, addr10;
  logic [31:0] rd1, rd10, wd1, wd10;
  logic        we1, we10, busy1, busy10, done1, done10, ovf1, ovf10;
  logic [31:0] mem1  [4096];
  logic [31:0] mem10 [4096];
  int          wr_cnt10 = 0;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] vin  [10] = '{32'h0001_0000, 32'h0000_4000, 32'h0002_0003, 32'hFFFF_0000,
                             32'h0000_FFFF, 32'h0010_0010, 32'h7FFF_0000, 32'h8000_0000,
                             32'h0000_0001, 32'h1234_5678};
  // Hand-computed for var2 = 0x4000.
  logic [31:0] vexp [10] = '{32'h0000_8000, 32'h0000_4000, 32'h0001_0002, 32'hFFFF_8000,
                             32'hFFFF_FFFE, 32'h0008_0010, 32'h3FFF_8000, 32'hC000_0000,
                             32'h0000_0000, 32'h091A_5678};

`ifdef MPY_32_16_VEC_ACC_EN
  logic [31:0] acc1, acc10, acc2, rd2, wd2;
  logic [11:0] addr2;
  logic        start2 = 1'b0, we2, busy2, done2, ovf2;
  logic [31:0] mem2 [4096];
`endif

  mpy_32_16_vec #(.LEN(1), .ADDR_W(12), .CNT_W(8)) u_len1 (
    .clock_i(clk), .reset_ni(rst_n), .start_i(start1), .var2_i(var2),
    .src_addr_i(src), .dst_addr_i(dst), .mem_addr_o(addr1), .mem_rd_data_i(rd1),
    .mem_wr_data_o(wd1), .mem_wr_en_o(we1), .busy_o(busy1), .done_o(done1),
    .overflow_o(ovf1)
`ifdef MPY_32_16_VEC_ACC_EN
    , .acc_out_o(acc1)
`endif
  );

  mpy_32_16_vec #(.LEN(10), .ADDR_W(12), .CNT_W(8)) u_len10 (
    .clock_i(clk), .reset_ni(rst_n), .start_i(start10), .var2_i(var2),
    .src_addr_i(src), .dst_addr_i(dst), .mem_addr_o(addr10), .mem_rd_data_i(rd10),
    .mem_wr_data_o(wd10), .mem_wr_en_o(we10), .busy_o(busy10), .done_o(done10),
    .overflow_o(ovf10)
`ifdef MPY_32_16_VEC_ACC_EN
    , .acc_out_o(acc10)
`endif
  );

`ifdef MPY_32_16_VEC_ACC_EN
  mpy_32_16_vec #(.LEN(2), .ADDR_W(12), .CNT_W(8)) u_len2 (
    .clock_i(clk), .reset_ni(rst_n), .start_i(start2), .var2_i(var2),
    .src_addr_i(src), .dst_addr_i(dst), .mem_addr_o(addr2), .mem_rd_data_i(rd2),
    .mem_wr_data_o(wd2), .mem_wr_en_o(we2), .busy_o(busy2), .done_o(done2),
    .overflow_o(ovf2), .acc_out_o(acc2)
  );

  always @(posedge clk) begin
    rd2 <= mem2[addr2];
    if (we2) mem2[addr2] <= wd2;
    else if (ld_en && ld_sel == 2) mem2[ld_addr] <= ld_data;
  end
`endif

  // Synchronous scratch memories: read data valid the cycle after the address.
  always @(posedge clk) begin
    rd1 <= mem1[addr1];
    if (we1) mem1[addr1] <= wd1;
    else if (ld_en && ld_sel == 1) mem1[ld_addr] <= ld_data;
  end

  always @(posedge clk) begin
    rd10 <= mem10[addr10];
    if (we10) begin
      mem10[addr10] <= wd10;
      wr_cnt10 <= wr_cnt10 + 1;
    end else if (ld_en && ld_sel == 10) mem10[ld_addr] <= ld_data;
  end

  function automatic logic done_of(input int which);
`ifdef MPY_32_16_VEC_ACC_EN
    if (which == 2) return done2;
`endif
    return (which == 1) ? done1 : done10;
  endfunction

  task automatic load(input int which, input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_sel = which; ld_addr = a; ld_data = d; ld_en = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Pulse start, return the number of edges after the accepting edge until done (-1 on timeout).
  task automatic run(input int which, output int cycles);
    @(negedge clk);
    if (which == 1) start1 = 1'b1;
    else if (which == 10) start10 = 1'b1;
`ifdef MPY_32_16_VEC_ACC_EN
    else start2 = 1'b1;
`endif
    @(posedge clk); #1;
    start1 = 1'b0; start10 = 1'b0;
`ifdef MPY_32_16_VEC_ACC_EN
    start2 = 1'b0;
`endif
    cycles = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (done_of(which)) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (addr1 !== 12'h000) begin miscompares++; $display("FAIL reset_addr got %h exp 000", addr1); end
    vectors++; if (wd1 !== 32'h0) begin miscompares++; $display("FAIL reset_wdata got %h exp 0", wd1); end
    vectors++; if (we1 !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b exp 0", we1); end
    vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy1); end
    vectors++; if (done1 !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", done1); end
    vectors++; if (ovf1 !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b exp 0", ovf1); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int c;
    load(1, 12'h010, 32'h0001_0000);
    var2 = 16'h4000; src = 12'h010; dst = 12'h020;
    run(1, c);
    vectors++; if (c != 5) begin miscompares++; $display("FAIL single_latency got %0d exp 5", c); end
    vectors++; if (mem1[12'h020] !== 32'h0000_8000) begin miscompares++; $display("FAIL single_result got %h exp 00008000", mem1[12'h020]); end
    vectors++; if (ovf1 !== 1'b0) begin miscompares++; $display("FAIL single_ovf got %b exp 0", ovf1); end
    vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL single_busy got %b exp 0", busy1); end
    vectors++; if (addr1 !== 12'h020) begin miscompares++; $display("FAIL single_addr_hold got %h exp 020", addr1); end
  endtask

  task automatic test_mult_lo();
    int c;
    load(1, 12'h011, 32'h0000_4000);
    var2 = 16'h4000; src = 12'h011; dst = 12'h021;
    run(1, c);
    vectors++; if (mem1[12'h021] !== 32'h0000_4000) begin miscompares++; $display("FAIL mult_lo_result got %h exp 00004000", mem1[12'h021]); end
    vectors++; if (ovf1 !== 1'b0) begin miscompares++; $display("FAIL mult_lo_ovf got %b exp 0", ovf1); end
  endtask

  task automatic test_saturate();
    int c;
    load(1, 12'h012, 32'h8000_0000);
    var2 = 16'h8000; src = 12'h012; dst = 12'h022;
    run(1, c);
    vectors++; if (mem1[12'h022] !== 32'h7FFF_FFFF) begin miscompares++; $display("FAIL sat_lmult_result got %h exp 7fffffff", mem1[12'h022]); end
    vectors++; if (ovf1 !== 1'b1) begin miscompares++; $display("FAIL sat_lmult_ovf got %b exp 1", ovf1); end
    repeat (5) @(posedge clk);
    #1;
    vectors++; if (ovf1 !== 1'b1) begin miscompares++; $display("FAIL sat_sticky got %b exp 1", ovf1); end
    // A clean run clears the sticky flag.
    var2 = 16'h4000; src = 12'h010; dst = 12'h023;
    run(1, c);
    vectors++; if (ovf1 !== 1'b0) begin miscompares++; $display("FAIL sat_clear_on_start got %b exp 0", ovf1); end
    vectors++; if (mem1[12'h023] !== 32'h0000_8000) begin miscompares++; $display("FAIL sat_clean_result got %h exp 00008000", mem1[12'h023]); end
    // lo = var2 = 0x8000 saturates mult to 0x7FFF.
    load(1, 12'h013, 32'h0000_8000);
    var2 = 16'h8000; src = 12'h013; dst = 12'h024;
    run(1, c);
    vectors++; if (mem1[12'h024] !== 32'h0000_FFFE) begin miscompares++; $display("FAIL sat_mult_result got %h exp 0000fffe", mem1[12'h024]); end
    vectors++; if (ovf1 !== 1'b1) begin miscompares++; $display("FAIL sat_mult_ovf got %b exp 1", ovf1); end
  endtask

  task automatic test_inplace_wrap();
    int c, base;
    logic [11:0] a;
    for (int k = 0; k < 10; k++) begin
      a = 12'hFF8 + 12'(k);
      load(10, a, vin[k]);
    end
    var2 = 16'h4000; src = 12'hFF8; dst = 12'hFF8;
    base = wr_cnt10;
    run(10, c);
    vectors++; if (c != 41) begin miscompares++; $display("FAIL wrap_latency got %0d exp 41", c); end
    vectors++; if (wr_cnt10 - base != 10) begin miscompares++; $display("FAIL wrap_write_count got %0d exp 10", wr_cnt10 - base); end
    vectors++; if (ovf10 !== 1'b0) begin miscompares++; $display("FAIL wrap_ovf got %b exp 0", ovf10); end
    for (int k = 0; k < 10; k++) begin
      a = 12'hFF8 + 12'(k);
      vectors++;
      if (mem10[a] !== vexp[k]) begin
        miscompares++;
        $display("FAIL wrap_elem%0d addr %h got %h exp %h", k, a, mem10[a], vexp[k]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int c, base;
    for (int k = 0; k < 10; k++) load(10, 12'h100 + 12'(k), vin[k]);
    var2 = 16'h4000; src = 12'h100; dst = 12'h200;
    base = wr_cnt10;
    @(negedge clk);
    start10 = 1'b1;
    @(posedge clk); #1;
    start10 = 1'b0;
    c = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (k == 6) begin
        start10 = 1'b1; var2 = 16'h8000; src = 12'h300;
      end else begin
        start10 = 1'b0;
      end
      if (done10) begin
        c = k;
        break;
      end
    end
    vectors++; if (c != 41) begin miscompares++; $display("FAIL busy_start_latency got %0d exp 41", c); end
    vectors++; if (wr_cnt10 - base != 10) begin miscompares++; $display("FAIL busy_start_writes got %0d exp 10", wr_cnt10 - base); end
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if (mem10[12'h200 + 12'(k)] !== vexp[k]) begin
        miscompares++;
        $display("FAIL busy_start_elem%0d got %h exp %h", k, mem10[12'h200 + 12'(k)], vexp[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int c, base;
    load(10, 12'h402, 32'hDEAD_BEEF);
    var2 = 16'h4000; src = 12'h100; dst = 12'h400;
    base = wr_cnt10;
    @(negedge clk);
    start10 = 1'b1;
    @(posedge clk); #1;
    start10 = 1'b0;
    repeat (10) @(posedge clk);
    // Now in the third element's CALC cycle.
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++; if (we10 !== 1'b0) begin miscompares++; $display("FAIL midrst_we got %b exp 0", we10); end
    vectors++; if (busy10 !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b exp 0", busy10); end
    vectors++; if (addr10 !== 12'h000) begin miscompares++; $display("FAIL midrst_addr got %h exp 000", addr10); end
    vectors++; if (wd10 !== 32'h0) begin miscompares++; $display("FAIL midrst_wdata got %h exp 0", wd10); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    vectors++; if (wr_cnt10 - base != 2) begin miscompares++; $display("FAIL midrst_writes got %0d exp 2", wr_cnt10 - base); end
    vectors++; if (mem10[12'h402] !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL midrst_no_write got %h exp deadbeef", mem10[12'h402]); end
    vectors++; if (mem10[12'h401] !== vexp[1]) begin miscompares++; $display("FAIL midrst_elem1 got %h exp %h", mem10[12'h401], vexp[1]); end
    run(10, c);
    vectors++; if (c != 41) begin miscompares++; $display("FAIL midrst_rerun_latency got %0d exp 41", c); end
    vectors++; if (mem10[12'h402] !== vexp[2]) begin miscompares++; $display("FAIL midrst_rerun_elem2 got %h exp %h", mem10[12'h402], vexp[2]); end
    vectors++; if (mem10[12'h409] !== vexp[9]) begin miscompares++; $display("FAIL midrst_rerun_elem9 got %h exp %h", mem10[12'h409], vexp[9]); end
  endtask

`ifdef MPY_32_16_VEC_ACC_EN
  task automatic test_acc();
    int c;
    load(2, 12'h050, 32'h0001_0000);
    load(2, 12'h051, 32'h0002_0000);
    var2 = 16'h4000; src = 12'h050; dst = 12'h060;
    run(2, c);
    vectors++; if (c != 9) begin miscompares++; $display("FAIL acc_latency got %0d exp 9", c); end
    vectors++; if (acc2 !== 32'h0001_8000) begin miscompares++; $display("FAIL acc_sum got %h exp 00018000", acc2); end
    vectors++; if (mem2[12'h061] !== 32'h0001_0000) begin miscompares++; $display("FAIL acc_elem1 got %h exp 00010000", mem2[12'h061]); end
    vectors++; if (ovf2 !== 1'b0) begin miscompares++; $display("FAIL acc_ovf got %b exp 0", ovf2); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_mult_lo();
    test_saturate();
    test_inplace_wrap();
    test_start_ignored();
    test_mid_reset();
`ifdef MPY_32_16_VEC_ACC_EN
    test_acc();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mpy_32_16_vec.md
Name: mpy_32_16_vec

Overview:
- Sequential, parametrised successor to the combinational 32x16 DPF multiply.
- Walks a vector of LEN 32-bit values in scratch memory and multiplies each by a 16-bit scalar latched at start, using G.729 mpy_32_16 bit-exact arithmetic.
- Writes each result to a destination vector through a start/done handshake.
- Arithmetic (L_mult, mult, L_mac with saturation) is internal; no external operator muxing is needed.

Parameters:
- LEN, 10, number of vector elements processed per start (1..2^ADDR_W).
- ADDR_W, 12, scratch memory address width.
- CNT_W, 8, element counter width; must hold LEN.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- var2  in  16  scalar multiplier; latched on accepted start.
- src_addr  in  ADDR_W  base address of the input vector; latched on start.
- dst_addr  in  ADDR_W  base address of the output vector; latched on start.
- mem_addr  out  ADDR_W  scratch memory address.
- mem_rd_data  in  32  read data, valid the cycle after mem_addr is driven.
- mem_wr_data  out  32  write data.
- mem_wr_en  out  1  write strobe.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- overflow  out  1  sticky saturation flag for the current run.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, counter=0.
  - mem_addr=0, mem_wr_data=0, mem_wr_en=0, busy=0, done=0, overflow=0.
  - Reset wins over every other event, including mid-run; the partial run is abandoned with no further writes.
- States: IDLE, RD, WAIT, CALC, WR, DONE.
  - IDLE: start=1 latches var2, src_addr and dst_addr; clears counter and overflow; goes to RD; busy=1 from the next cycle. start is ignored in every other state.
  - RD: mem_addr=src+i; go to WAIT.
  - WAIT: capture mem_rd_data into var1; go to CALC.
  - CALC: compute result and register it; go to WR.
  - WR: mem_addr=dst+i, mem_wr_data=result, mem_wr_en=1 for exactly this cycle. If i==LEN-1 go to DONE; else i=i+1 and go to RD.
  - DONE: done=1 for one cycle, busy=0; go to IDLE.
- Latency: 4 cycles per element. done asserts 4*LEN+1 cycles after the accepting edge.
- Addresses wrap modulo 2^ADDR_W. src==dst (in-place) is legal: each element is read before it is written.
- Arithmetic, with hi=var1[31:16] and lo=var1[15:0], both signed 16-bit:
  - L_mult(a,b) = 2*a*b. If a==b==0x8000, result is 0x7FFFFFFF with saturation.
  - mult(a,b) = (a*b)>>15, arithmetic shift. If a==b==0x8000, result is 0x7FFF with saturation.
  - result = sat32( L_mult(hi,var2) + 2*sext(mult(lo,var2)) ), i.e. L_mac(acc, m, 1).
  - Any saturation in any step sets overflow. overflow stays set until the next accepted start or reset.
- Outputs are registered. mem_addr holds its last value when not in RD/WR.

Optional Feature:
- Macro: MPY_32_16_VEC_ACC_EN.
- Defined:
  - Adds output acc_out (32 bits, reset 0).
  - acc_out clears on accepted start and in WR takes sat32(acc_out + result); overflow also covers this sum.
  - acc_out is final when done pulses and holds until the next start.
- Undefined: no acc_out port and no accumulator logic.

Test Plan:
- LEN=1, mem[src]=0x00010000, var2=0x4000 -> mem[dst]=0x00008000, overflow=0, done exactly 5 cycles after start.
- mem[src]=0x00004000, var2=0x4000 -> mult=0x2000, result 0x00004000, overflow=0.
- mem[src]=0x80000000, var2=0x8000 -> result 0x7FFFFFFF, overflow=1, and overflow stays 1 until the next start.
- LEN=10, src==dst=0x0FF8 (wrap to 0x000) -> all 10 elements updated in place at 0xFF8..0xFFF and 0x000..0x001; exactly 10 mem_wr_en pulses; done at cycle 41.
- Assert reset=0 during the 3rd element's CALC -> outputs reach reset values next edge, no further writes; start afterwards runs normally. Also: start while busy is ignored.
- ACC_EN with LEN=2, inputs 0x00010000 and 0x00020000, var2=0x4000 -> acc_out=0x00018000 at done.
